// File: rtl/ld_ex_stage_buf.sv
// Load-to-execute pipeline stage: valid/ready handshake with a 2-entry skid
// buffer, synchronous flush, halt-drain state machine and a stall counter.
module ld_ex_stage_buf #(
  parameter int DATA_W  = 6,
  parameter int ADR_W   = 6,
  parameter int ALU_W   = 2,
  parameter int NUM_OPS = 2,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_halted,
  input  logic [ADR_W-1:0]          in_write_adr,
  input  logic [ALU_W-1:0]          in_alu_inst,
  input  logic [NUM_OPS*DATA_W-1:0] in_data,
  input  logic                      in_mem_write,
  input  logic                      in_mul_or_add,
  input  logic                      freeze,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_halted,
  output logic [ADR_W-1:0]          out_write_adr,
  output logic [ALU_W-1:0]          out_alu_inst,
  output logic [NUM_OPS*DATA_W-1:0] out_data,
  output logic                      out_mem_write,
  output logic                      out_mul_or_add,
  output logic                      core_halted,
  output logic [CNT_W-1:0]          stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic                      halted;
    logic [ADR_W-1:0]          write_adr;
    logic [ALU_W-1:0]          alu_inst;
    logic [NUM_OPS*DATA_W-1:0] data;
    logic                      mem_write;
    logic                      mul_or_add;
  } entry_t;

  state_t state, state_next;
  entry_t head, skid, in_entry;
  logic   head_valid, skid_valid;
  logic   accept, deq;

  assign in_entry = '{halted: in_halted, write_adr: in_write_adr, alu_inst: in_alu_inst,
                      data: in_data, mem_write: in_mem_write, mul_or_add: in_mul_or_add};

  // Gated by rst_n so that every output reads 0 while reset is held.
  assign in_ready = rst_n && !skid_valid && (state == RUN) && !freeze && !flush;
  assign accept   = in_valid && in_ready;
  assign deq      = head_valid && out_ready && !freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      skid       <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!freeze) begin
      if (deq && skid_valid) begin
        head       <= skid;
        skid_valid <= 1'b0;
      end else if (deq) begin
        head_valid <= accept;
        if (accept) head <= in_entry;
      end else if (accept) begin
        if (!head_valid) begin
          head       <= in_entry;
          head_valid <= 1'b1;
        end else begin
          skid       <= in_entry;
          skid_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // A deq that coincides with flush is ignored, so flush wins in DRAIN.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (accept && in_halted) state_next = DRAIN;
      DRAIN: begin
        if (flush)                          state_next = RUN;
        else if (deq && head.halted)        state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (head_valid && (!out_ready || freeze) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid      = head_valid;
  assign out_halted     = head.halted;
  assign out_write_adr  = head.write_adr;
  assign out_alu_inst   = head.alu_inst;
  assign out_data       = head.data;
  assign out_mem_write  = head.mem_write;
  assign out_mul_or_add = head.mul_or_add;
  assign core_halted    = (state == HALTED);

endmodule

// File: tb/tb_ld_ex_stage_buf.sv
// Self-checking bench for ld_ex_stage_buf: a vector table for streaming and
// backpressure, plus hand sequences for freeze, halt, flush, reset, saturation.
module tb_ld_ex_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_halted;
  logic [5:0]  in_write_adr;
  logic [1:0]  in_alu_inst;
  logic [11:0] in_data;
  logic        in_mem_write, in_mul_or_add;
  logic        freeze, flush;
  logic        out_valid, out_ready, out_halted;
  logic [5:0]  out_write_adr;
  logic [1:0]  out_alu_inst;
  logic [11:0] out_data;
  logic        out_mem_write, out_mul_or_add;
  logic        core_halted;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       iv;
    logic       ih;
    logic [5:0] adr;
    logic       ordy;
    logic       frz;
    logic       fl;
    logic       exp_ov;
    logic [5:0] exp_adr;
    logic       exp_ir;
  } vec_t;

  vec_t vecs[12];

  ld_ex_stage_buf dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_halted(in_halted),
    .in_write_adr(in_write_adr), .in_alu_inst(in_alu_inst), .in_data(in_data),
    .in_mem_write(in_mem_write), .in_mul_or_add(in_mul_or_add),
    .freeze(freeze), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_halted(out_halted),
    .out_write_adr(out_write_adr), .out_alu_inst(out_alu_inst), .out_data(out_data),
    .out_mem_write(out_mem_write), .out_mul_or_add(out_mul_or_add),
    .core_halted(core_halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // All payload fields are derived from the write address so one number identifies an entry.
  task automatic applyStimulus(input logic iv, input logic ih, input logic [5:0] adr,
                               input logic ordy, input logic frz, input logic fl);
    in_valid      = iv;
    in_halted     = ih;
    in_write_adr  = adr;
    in_alu_inst   = adr[1:0];
    in_data       = {adr + 6'd20, adr};
    in_mem_write  = adr[0];
    in_mul_or_add = adr[1];
    out_ready     = ordy;
    freeze        = frz;
    flush         = fl;
  endtask

  task automatic checkOutput(input string name, input logic exp_ov, input logic [5:0] exp_adr,
                             input logic exp_ir);
    logic [11:0] exp_data;
    #1;
    exp_data = {exp_adr + 6'd20, exp_adr};
    check({name, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    check({name, ".in_ready"}, 32'(in_ready), 32'(exp_ir));
    if (exp_ov) begin
      check({name, ".out_write_adr"}, 32'(out_write_adr), 32'(exp_adr));
      check({name, ".out_data"}, 32'(out_data), 32'(exp_data));
      check({name, ".out_alu_inst"}, 32'(out_alu_inst), 32'(exp_adr[1:0]));
      check({name, ".out_mem_write"}, 32'(out_mem_write), 32'(exp_adr[0]));
      check({name, ".out_mul_or_add"}, 32'(out_mul_or_add), 32'(exp_adr[1]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, ".out_valid"}, 32'(out_valid), 32'd0);
    check({name, ".in_ready"}, 32'(in_ready), 32'd0);
    check({name, ".out_write_adr"}, 32'(out_write_adr), 32'd0);
    check({name, ".out_data"}, 32'(out_data), 32'd0);
    check({name, ".out_halted"}, 32'(out_halted), 32'd0);
    check({name, ".core_halted"}, 32'(core_halted), 32'd0);
    check({name, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    // Streaming 1..4, then backpressure with A=5 held and B=6 parked in the skid.
    vecs[0]  = '{1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 6'd6, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 6'd7, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd6, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("release", 1'b0, 6'd0, 1'b1);
    check("release.stall_cnt", 32'(stall_cnt), 32'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].ih, vecs[i].adr, vecs[i].ordy, vecs[i].frz, vecs[i].fl);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_adr, vecs[i].exp_ir);
      tick();
    end
    check("bp.stall_cnt", 32'(stall_cnt), 32'd2);

    // Freeze: head holds adr 7 for three frozen cycles, adr 8 must not get in.
    applyStimulus(1'b1, 1'b0, 6'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("frz_load", 1'b0, 6'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd8, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("frz_hold%0d", i), 1'b1, 6'd7, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("frz_release", 1'b1, 6'd7, 1'b1);
    tick();
    checkOutput("frz_drained", 1'b0, 6'd0, 1'b1);
    check("frz.stall_cnt", 32'(stall_cnt), 32'd5);

    // Halt: adr 9 carries the halt, adr 10 must never be accepted.
    applyStimulus(1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_accept", 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd10, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_drain", 1'b1, 6'd9, 1'b0);
    check("halt_drain.out_halted", 32'(out_halted), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd10, 1'b1, 1'b0, 1'b0);
    checkOutput("halt_deq", 1'b1, 6'd9, 1'b0);
    check("halt_deq.core_halted", 32'(core_halted), 32'd0);
    tick();
    checkOutput("halted", 1'b0, 6'd0, 1'b0);
    check("halted.core_halted", 32'(core_halted), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd10, 1'b1, 1'b0, 1'b0);
    checkOutput("halted_flush", 1'b0, 6'd0, 1'b0);
    check("halted_flush.core_halted", 32'(core_halted), 32'd1);

    // Only reset leaves HALTED.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset", 1'b0, 6'd0, 1'b1);
    check("post_reset.stall_cnt", 32'(stall_cnt), 32'd0);
    check("post_reset.core_halted", 32'(core_halted), 32'd0);

    // Flush with both head and skid full, while a new entry is offered.
    applyStimulus(1'b1, 1'b0, 6'd11, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_fill_head", 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd12, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_fill_skid", 1'b1, 6'd11, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd13, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_full", 1'b1, 6'd11, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("after_flush", 1'b0, 6'd0, 1'b1);
    tick();

    // Flush while draining returns to RUN.
    applyStimulus(1'b1, 1'b1, 6'd14, 1'b0, 1'b0, 1'b0);
    checkOutput("dr_accept", 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd15, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_flush", 1'b1, 6'd14, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_flush_after", 1'b0, 6'd0, 1'b1);
    check("drain_flush_after.core_halted", 32'(core_halted), 32'd0);
    tick();

    // Saturation: a long stall must stop at 255.
    applyStimulus(1'b1, 1'b0, 6'd20, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_load", 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (300) tick();
    checkOutput("sat_hold", 1'b1, 6'd20, 1'b1);
    check("sat.stall_cnt", 32'(stall_cnt), 32'd255);

    // Reset mid-transfer clears everything without waiting for a clock edge.
    applyStimulus(1'b1, 1'b0, 6'd21, 1'b1, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    tick();
    rst_n = 1'b1;
    checkOutput("async_release", 1'b0, 6'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
